msrv32_instr_decode_reg: RTL and testbench

Instruction register stage between the instruction-fetch return path and the immediate generator/decoder. It accepts fetched instructions and their PCs over a valid/ready handshake and registers them. Alongside each instruction it produces the registered 3-bit `imm_type` code consumed by the immediate generator, plus an illegal-opcode flag. It absorbs one cycle of downstream backpressure with a skid entry and supports pipeline flush.

---
 rtl/msrv32_instr_decode_reg.sv | 149 ++++++++++++++
 tb/tb_msrv32_instr_decode_reg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_instr_decode_reg.sv
// Instruction register stage: registers fetched instruction/PC with imm_type and illegal-opcode decode.
// Define MSRV32_IR_SKID_EN for a registered-ready two-slot (OUT + SKID) buffer; default is a single slot.
module msrv32_instr_decode_reg #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        flush_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic        instr_valid_in,
  output logic        instr_ready_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [2:0]  imm_type_out,
  output logic        illegal_out,
  output logic        valid_out,
  input  logic        ready_in
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  imm_type;
    logic        illegal;
  } entry_t;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;

  // Flush and reset both leave a NOP (addi x0,x0,0) in the output slot.
  localparam entry_t RESET_ENTRY = '{instr: 32'h0000_0013, pc: PC_RESET,
                                     imm_type: 3'b001, illegal: 1'b0};

  function automatic entry_t decode(input logic [31:0] instr, input logic [31:0] pc);
    entry_t e;
    e.instr    = instr;
    e.pc       = pc;
    e.imm_type = 3'b000;
    e.illegal  = 1'b0;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: e.imm_type = 3'b001;
      OPC_STORE:             e.imm_type = 3'b010;
      OPC_BRANCH:            e.imm_type = 3'b011;
      OPC_LUI, OPC_AUIPC:    e.imm_type = 3'b100;
      OPC_JAL:               e.imm_type = 3'b101;
      OPC_SYSTEM:            e.imm_type = instr[14] ? 3'b110 : 3'b111;
      OPC_OP:                e.imm_type = 3'b000;
      default:               e.illegal  = 1'b1;
    endcase
    return e;
  endfunction

  entry_t out_q, out_d;
  logic   out_valid_q, out_valid_d;
  entry_t in_entry;
  logic   in_xfer;

  assign in_entry = decode(instr_in, pc_in);
  assign in_xfer  = instr_valid_in & instr_ready_out & ~flush_in;

`ifdef MSRV32_IR_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_valid_q, skid_valid_d;

  assign instr_ready_out = ~skid_valid_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || ready_in) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
    if (flush_in) begin
      out_d        = RESET_ENTRY;
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      skid_q       <= RESET_ENTRY;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  // Single slot: ready must look through a consuming downstream, so it is combinational.
  assign instr_ready_out = ~out_valid_q | ready_in;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (!out_valid_q || ready_in) begin
      out_valid_d = in_xfer;
      if (in_xfer) out_d = in_entry;
    end
    if (flush_in) begin
      out_d       = RESET_ENTRY;
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n_in) begin
      out_q       <= RESET_ENTRY;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign instr_out    = out_q.instr;
  assign pc_out       = out_q.pc;
  assign imm_type_out = out_q.imm_type;
  assign illegal_out  = out_q.illegal;
  assign valid_out    = out_valid_q;

endmodule

// File: tb/tb_msrv32_instr_decode_reg.sv
// Scoreboard bench for msrv32_instr_decode_reg; expected ready follows MSRV32_IR_SKID_EN when defined.
module tb_msrv32_instr_decode_reg;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        flush_in;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        instr_valid_in;
  logic        instr_ready_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [2:0]  imm_type_out;
  logic        illegal_out;
  logic        valid_out;
  logic        ready_in;

  msrv32_instr_decode_reg #(.PC_RESET(32'h0000_0000)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in),
    .instr_in(instr_in), .pc_in(pc_in), .instr_valid_in(instr_valid_in),
    .instr_ready_out(instr_ready_out), .instr_out(instr_out), .pc_out(pc_out),
    .imm_type_out(imm_type_out), .illegal_out(illegal_out),
    .valid_out(valid_out), .ready_in(ready_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  imm;
    logic        ill;
  } exp_t;

  exp_t stim_q[$];
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   idle_known = 1'b0;
  logic [31:0] next_pc = 32'h0000_1000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr; e.pc = pc; e.ill = 1'b0;
    unique case (instr[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F: e.imm = 3'd1;
      7'h23: e.imm = 3'd2;
      7'h63: e.imm = 3'd3;
      7'h37, 7'h17: e.imm = 3'd4;
      7'h6F: e.imm = 3'd5;
      7'h73: e.imm = (instr[14:12] >= 3'd4) ? 3'd6 : 3'd7;
      7'h33: e.imm = 3'd0;
      default: begin e.imm = 3'd0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic add_auto(input logic [31:0] instr);
    stim_q.push_back(ref_decode(instr, next_pc));
    next_pc += 4;
  endtask

  task automatic add_fixed(input logic [31:0] instr, input logic [2:0] imm, input logic ill);
    exp_t e;
    e.instr = instr; e.pc = next_pc; e.imm = imm; e.ill = ill;
    stim_q.push_back(e);
    next_pc += 4;
  endtask

  task automatic check_idle_vals(input string tag);
    check({tag, "_instr"}, instr_out, 32'h0000_0013);
    check({tag, "_pc"}, pc_out, 32'h0000_0000);
    check({tag, "_imm"}, {29'd0, imm_type_out}, 32'd1);
    check({tag, "_ill"}, {31'd0, illegal_out}, 32'd0);
  endtask

  // One clock cycle: drive at negedge, compare against the scoreboard head, advance the model.
  task automatic step(input logic rdy, input logic flush, input logic offer);
    logic exp_rdy, in_x, out_x;
    @(negedge clk_in);
    ready_in = rdy;
    flush_in = flush;
    if (offer && stim_q.size() > 0) begin
      instr_valid_in = 1'b1;
      instr_in = stim_q[0].instr;
      pc_in    = stim_q[0].pc;
    end else begin
      instr_valid_in = 1'b0;
      instr_in = $urandom;
      pc_in    = $urandom;
    end
    #1;
`ifdef MSRV32_IR_SKID_EN
    exp_rdy = (sb_q.size() < 2);
`else
    exp_rdy = (sb_q.size() == 0) || rdy;
`endif
    check("ready", {31'd0, instr_ready_out}, {31'd0, exp_rdy});
    check("valid", {31'd0, valid_out}, (sb_q.size() != 0) ? 32'd1 : 32'd0);
    if (sb_q.size() != 0) begin
      check("instr", instr_out, sb_q[0].instr);
      check("pc", pc_out, sb_q[0].pc);
      check("imm", {29'd0, imm_type_out}, {29'd0, sb_q[0].imm});
      check("ill", {31'd0, illegal_out}, {31'd0, sb_q[0].ill});
    end else if (idle_known) begin
      check_idle_vals("idle");
    end
    in_x  = instr_valid_in && exp_rdy && !flush;
    out_x = (sb_q.size() != 0) && rdy;
    if (flush) begin
      sb_q.delete();
      if (instr_valid_in) void'(stim_q.pop_front());
      idle_known = 1'b1;
    end else begin
      if (out_x) void'(sb_q.pop_front());
      if (in_x) begin
        sb_q.push_back(stim_q.pop_front());
        idle_known = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || stim_q.size() != 0) && n < 64) begin
      step(1'b1, 1'b0, 1'b1);
      n++;
    end
    check("drain_left", sb_q.size() + stim_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ops [12];
    ops = '{32'h00500093, 32'h00112023, 32'h00000463, 32'h123450B7, 32'h008000EF,
            32'h3400D073, 32'h34001073, 32'h00208033, 32'h0000007F, 32'h00000017,
            32'h0000000F, 32'h00008067};
    rst_n_in = 1'b0; flush_in = 1'b0; instr_valid_in = 1'b0;
    instr_in = 32'd0; pc_in = 32'd0; ready_in = 1'b0;

    // Reset state while held in reset.
    repeat (2) @(negedge clk_in);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_ready", {31'd0, instr_ready_out}, 32'd1);
    check_idle_vals("rst");
    rst_n_in = 1'b1;
    idle_known = 1'b1;

    // Back-to-back decode stream with fixed expected imm_type values.
    add_fixed(32'h00500093, 3'b001, 1'b0);
    add_fixed(32'h00112023, 3'b010, 1'b0);
    add_fixed(32'h00000463, 3'b011, 1'b0);
    add_fixed(32'h123450B7, 3'b100, 1'b0);
    add_fixed(32'h008000EF, 3'b101, 1'b0);
    add_fixed(32'h3400D073, 3'b110, 1'b0);
    add_fixed(32'h34001073, 3'b111, 1'b0);
    add_fixed(32'h00208033, 3'b000, 1'b0);
    drain();

    // Illegal opcodes, including low bits not 11.
    add_fixed(32'h0000007F, 3'b000, 1'b1);
    add_fixed(32'h00000010, 3'b000, 1'b1);
    drain();

    // Backpressure: three stalled cycles, then release.
    add_auto(32'h00112023);
    add_auto(32'h00000463);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    drain();

    // Flush with slots occupied and a valid input in the same cycle.
    add_auto(32'h00500093);
    add_auto(32'h00112023);
    add_auto(32'hDEAD0013);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    stim_q.delete();
    repeat (3) step(1'b1, 1'b0, 1'b0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      while (stim_q.size() < 4) begin
        if ($urandom_range(3) == 0) add_auto($urandom);
        else add_auto(ops[$urandom_range(11)]);
      end
      step(1'($urandom_range(2) != 0), 1'($urandom_range(31) == 0), 1'($urandom_range(3) != 0));
    end
    drain();

    // Asynchronous reset asserted mid-stall between clock edges.
    add_auto(32'h00112023);
    add_auto(32'h00000463);
    add_auto(32'h00500093);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    @(posedge clk_in);
    #2;
    instr_valid_in = 1'b0;
    flush_in = 1'b0;
    rst_n_in = 1'b0;
    #1;
    check("arst_valid", {31'd0, valid_out}, 32'd0);
    check("arst_ready", {31'd0, instr_ready_out}, 32'd1);
    check_idle_vals("arst");
    sb_q.delete();
    stim_q.delete();
    idle_known = 1'b1;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    add_auto(32'h008000EF);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
